// File: rtl/e203_lsu_icb_router.sv
// LSU-side ICB router: decodes each command by address region onto N_TGT target ports and keeps responses in order.
// Optional exclusive (LR/SC) reservation monitor enabled by defining E203_LSU_EXCL_MON_EN.
module e203_lsu_icb_router #(
  parameter int N_TGT      = 3,
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int OUTS_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  commit_mret,
  input  logic                  commit_trap,
  input  logic                  excp_active,
  output logic                  lsu_active,
  input  logic                  i_icb_cmd_valid,
  output logic                  i_icb_cmd_ready,
  input  logic [AW-1:0]         i_icb_cmd_addr,
  input  logic                  i_icb_cmd_read,
  input  logic [DW-1:0]         i_icb_cmd_wdata,
  input  logic [DW/8-1:0]       i_icb_cmd_wmask,
  input  logic                  i_icb_cmd_lock,
  input  logic                  i_icb_cmd_excl,
  input  logic [1:0]            i_icb_cmd_size,
  output logic                  i_icb_rsp_valid,
  input  logic                  i_icb_rsp_ready,
  output logic                  i_icb_rsp_err,
  output logic                  i_icb_rsp_excl_ok,
  output logic [DW-1:0]         i_icb_rsp_rdata,
  input  logic [N_TGT*AW-1:0]   tgt_region_base,
  input  logic [N_TGT*AW-1:0]   tgt_region_mask,
  output logic [N_TGT-1:0]      o_icb_cmd_valid,
  input  logic [N_TGT-1:0]      o_icb_cmd_ready,
  output logic [N_TGT*AW-1:0]   o_icb_cmd_addr,
  output logic [N_TGT-1:0]      o_icb_cmd_read,
  output logic [N_TGT-1:0]      o_icb_cmd_lock,
  output logic [N_TGT-1:0]      o_icb_cmd_excl,
  output logic [N_TGT*DW-1:0]   o_icb_cmd_wdata,
  output logic [N_TGT*DW/8-1:0] o_icb_cmd_wmask,
  output logic [N_TGT*2-1:0]    o_icb_cmd_size,
  input  logic [N_TGT-1:0]      o_icb_rsp_valid,
  output logic [N_TGT-1:0]      o_icb_rsp_ready,
  input  logic [N_TGT-1:0]      o_icb_rsp_err,
  input  logic [N_TGT-1:0]      o_icb_rsp_excl_ok,
  input  logic [N_TGT*DW-1:0]   o_icb_rsp_rdata
);

  localparam int MW = DW / 8;
  localparam int TW = (N_TGT > 1) ? $clog2(N_TGT) : 1;
  localparam int PW = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
  localparam int CW = $clog2(OUTS_DEPTH + 1);

  logic [TW-1:0] sel_s;
  logic [TW-1:0] head_s;
  logic [TW-1:0] last_tgt_r;
  logic [PW-1:0] wptr_r;
  logic [PW-1:0] rptr_r;
  logic [CW-1:0] count_r;
  logic [TW-1:0] fifo_tgt_r [OUTS_DEPTH];
  logic          empty_s;
  logic          full_s;
  logic          block_s;
  logic          cmd_hsk_s;
  logic          rsp_hsk_s;
  logic [MW-1:0] wmask_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OUTS_DEPTH - 1)) ? PW'(0) : (p + PW'(1));
  endfunction

  // Lowest-index hitting region wins; the last target is the fallback and its region is ignored.
  always_comb begin
    sel_s = TW'(N_TGT - 1);
    for (int k = N_TGT - 2; k >= 0; k--) begin
      sel_s = ((i_icb_cmd_addr & tgt_region_mask[k*AW +: AW]) ==
               (tgt_region_base[k*AW +: AW] & tgt_region_mask[k*AW +: AW])) ? TW'(k) : sel_s;
    end
  end

  assign empty_s   = (count_r == CW'(0));
  assign full_s    = (count_r == CW'(OUTS_DEPTH));
  // Outstanding entries always share one target, so responses can only come back in order.
  assign block_s   = full_s | (~empty_s & (sel_s != last_tgt_r));
  assign i_icb_cmd_ready = ~block_s & o_icb_cmd_ready[sel_s];
  assign cmd_hsk_s = i_icb_cmd_valid & i_icb_cmd_ready;

  assign o_icb_cmd_addr  = {N_TGT{i_icb_cmd_addr}};
  assign o_icb_cmd_read  = {N_TGT{i_icb_cmd_read}};
  assign o_icb_cmd_lock  = {N_TGT{i_icb_cmd_lock}};
  assign o_icb_cmd_excl  = {N_TGT{i_icb_cmd_excl}};
  assign o_icb_cmd_wdata = {N_TGT{i_icb_cmd_wdata}};
  assign o_icb_cmd_wmask = {N_TGT{wmask_s}};
  assign o_icb_cmd_size  = {N_TGT{i_icb_cmd_size}};

  // Only the selected target sees a valid command, and only when ordering allows it.
  always_comb begin
    o_icb_cmd_valid = {N_TGT{1'b0}};
    for (int k = 0; k < N_TGT; k++) begin
      o_icb_cmd_valid[k] = (sel_s == TW'(k)) & ~block_s & i_icb_cmd_valid;
    end
  end

  assign head_s = fifo_tgt_r[rptr_r];

  // Response mux steered by the head entry's target id.
  always_comb begin
    i_icb_rsp_rdata = {DW{1'b0}};
    o_icb_rsp_ready = {N_TGT{1'b0}};
    for (int k = 0; k < N_TGT; k++) begin
      i_icb_rsp_rdata    = (head_s == TW'(k)) ? o_icb_rsp_rdata[k*DW +: DW] : i_icb_rsp_rdata;
      o_icb_rsp_ready[k] = ~empty_s & (head_s == TW'(k)) & i_icb_rsp_ready;
    end
  end

  assign i_icb_rsp_valid = ~empty_s & o_icb_rsp_valid[head_s];
  assign i_icb_rsp_err   = o_icb_rsp_err[head_s];
  assign rsp_hsk_s       = i_icb_rsp_valid & i_icb_rsp_ready;
  assign lsu_active      = (count_r != CW'(0)) | i_icb_cmd_valid | excp_active;

  // Outstanding FIFO: target ids, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r    <= CW'(0);
      wptr_r     <= PW'(0);
      rptr_r     <= PW'(0);
      last_tgt_r <= TW'(0);
      for (int i = 0; i < OUTS_DEPTH; i++) begin
        fifo_tgt_r[i] <= TW'(0);
      end
    end else begin
      if (cmd_hsk_s) begin
        fifo_tgt_r[wptr_r] <= sel_s;
        wptr_r             <= ptr_inc(wptr_r);
        last_tgt_r         <= sel_s;
      end
      if (rsp_hsk_s) begin
        rptr_r <= ptr_inc(rptr_r);
      end
      case ({cmd_hsk_s, rsp_hsk_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

`ifdef E203_LSU_EXCL_MON_EN
  logic          resv_valid_r;
  logic [AW-1:0] resv_addr_r;
  logic          excl_fail_r [OUTS_DEPTH];
  logic          excl_wr_s;
  logic          push_fail_s;
  logic          unused_s;

  assign excl_wr_s   = i_icb_cmd_excl & ~i_icb_cmd_read;
  assign push_fail_s = excl_wr_s & ~(resv_valid_r & (resv_addr_r == i_icb_cmd_addr));
  // A failing store-conditional still goes out, but with no byte lanes enabled.
  assign wmask_s     = push_fail_s ? {MW{1'b0}} : i_icb_cmd_wmask;
  assign i_icb_rsp_excl_ok = ~excl_fail_r[rptr_r] & o_icb_rsp_excl_ok[head_s];
  assign unused_s    = ^{tgt_region_base[N_TGT*AW-1 -: AW], tgt_region_mask[N_TGT*AW-1 -: AW]};

  // Reservation: LR sets it (winning over commit events), SC or commit clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resv_valid_r <= 1'b0;
      resv_addr_r  <= {AW{1'b0}};
    end else if (cmd_hsk_s & i_icb_cmd_excl & i_icb_cmd_read) begin
      resv_valid_r <= 1'b1;
      resv_addr_r  <= i_icb_cmd_addr;
    end else if ((cmd_hsk_s & excl_wr_s) | commit_mret | commit_trap) begin
      resv_valid_r <= 1'b0;
    end else begin
      resv_valid_r <= resv_valid_r;
    end
  end

  // Per-entry exclusive-fail flag, written alongside the target id.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OUTS_DEPTH; i++) begin
        excl_fail_r[i] <= 1'b0;
      end
    end else if (cmd_hsk_s) begin
      excl_fail_r[wptr_r] <= push_fail_s;
    end else begin
      excl_fail_r[wptr_r] <= excl_fail_r[wptr_r];
    end
  end
`else
  logic unused_s;

  assign wmask_s           = i_icb_cmd_wmask;
  assign i_icb_rsp_excl_ok = o_icb_rsp_excl_ok[head_s];
  assign unused_s          = ^{commit_mret, commit_trap,
                               tgt_region_base[N_TGT*AW-1 -: AW], tgt_region_mask[N_TGT*AW-1 -: AW]};
`endif

endmodule

// File: tb/tb_e203_lsu_icb_router.sv
// Self-checking bench for e203_lsu_icb_router: directed scenarios plus a randomized run
// checked against a queue-based model of the routing and in-order response rules.
module tb_e203_lsu_icb_router;
  localparam int N = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic commit_mret, commit_trap, excp_active, lsu_active;
  logic cv, cr, cread, clock, cexcl;
  logic [AW-1:0] caddr;
  logic [DW-1:0] cwdata;
  logic [3:0] cwmask;
  logic [1:0] csize;
  logic rv, rr, rerr, rok;
  logic [DW-1:0] rdata;
  logic [N*AW-1:0] rbase, rmask;
  logic [N-1:0] ocv, ocr, oread, olock, oexcl;
  logic [N*AW-1:0] oaddr;
  logic [N*DW-1:0] owdata;
  logic [N*4-1:0] owmask;
  logic [N*2-1:0] osize;
  logic [N-1:0] orv, orr, oerr, ook;
  logic [N*DW-1:0] ordata;

  typedef struct {int tgt; logic [31:0] data; logic err;} ent_t;
  ent_t q[$];
  int vectors = 0;
  int errors = 0;

  always #5 clk = ~clk;

  e203_lsu_icb_router #(.N_TGT(N), .AW(AW), .DW(DW), .OUTS_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .commit_mret(commit_mret), .commit_trap(commit_trap),
    .excp_active(excp_active), .lsu_active(lsu_active),
    .i_icb_cmd_valid(cv), .i_icb_cmd_ready(cr), .i_icb_cmd_addr(caddr), .i_icb_cmd_read(cread),
    .i_icb_cmd_wdata(cwdata), .i_icb_cmd_wmask(cwmask), .i_icb_cmd_lock(clock),
    .i_icb_cmd_excl(cexcl), .i_icb_cmd_size(csize),
    .i_icb_rsp_valid(rv), .i_icb_rsp_ready(rr), .i_icb_rsp_err(rerr),
    .i_icb_rsp_excl_ok(rok), .i_icb_rsp_rdata(rdata),
    .tgt_region_base(rbase), .tgt_region_mask(rmask),
    .o_icb_cmd_valid(ocv), .o_icb_cmd_ready(ocr), .o_icb_cmd_addr(oaddr), .o_icb_cmd_read(oread),
    .o_icb_cmd_lock(olock), .o_icb_cmd_excl(oexcl), .o_icb_cmd_wdata(owdata),
    .o_icb_cmd_wmask(owmask), .o_icb_cmd_size(osize),
    .o_icb_rsp_valid(orv), .o_icb_rsp_ready(orr), .o_icb_rsp_err(oerr),
    .o_icb_rsp_excl_ok(ook), .o_icb_rsp_rdata(ordata)
  );

  function automatic int ref_sel(input logic [31:0] a);
    for (int k = 0; k < N - 1; k++) begin
      if ((a & rmask[k*AW +: AW]) == (rbase[k*AW +: AW] & rmask[k*AW +: AW])) return k;
    end
    return N - 1;
  endfunction

  task automatic idle;
    cv = 1'b0; caddr = 32'h0; cread = 1'b1; cwdata = 32'h0; cwmask = 4'h0;
    clock = 1'b0; cexcl = 1'b0; csize = 2'd2; rr = 1'b0; ocr = 3'b000;
    orv = 3'b000; oerr = 3'b000; ook = 3'b000; ordata = '0;
    commit_mret = 1'b0; commit_trap = 1'b0; excp_active = 1'b0;
  endtask

  task automatic do_reset;
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    q.delete();
  endtask

  task automatic test_reset;
    idle();
    rst_n = 1'b0;
    #2;
    vectors++; if (rv !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rv); end
    vectors++; if (orr !== 3'b000) begin errors++; $display("FAIL reset_rsp_ready got %b want 000", orr); end
    vectors++; if (lsu_active !== 1'b0) begin errors++; $display("FAIL reset_lsu_active got %b want 0", lsu_active); end
    excp_active = 1'b1; #1;
    vectors++; if (lsu_active !== 1'b1) begin errors++; $display("FAIL reset_excp_active got %b want 1", lsu_active); end
    excp_active = 1'b0; cv = 1'b1; caddr = 32'h1000_0000; #1;
    vectors++; if (ocv !== 3'b100) begin errors++; $display("FAIL reset_cmd_follow got %b want 100", ocv); end
    vectors++; if (cr !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready got %b want 0", cr); end
    do_reset();
  endtask

  task automatic test_decode;
    logic [31:0] a;
    logic [2:0] exp;
    do_reset();
    cv = 1'b1; ocr = 3'b000;
    for (int i = 0; i < 15; i++) begin
      case (i)
        0: a = 32'h8000_0010;
        1: a = 32'h9000_0004;
        2: a = 32'h1000_0000;
        default: case ($urandom_range(0, 2))
          0: a = 32'h8000_0000 | ($urandom & 32'h0000_FFFF);
          1: a = 32'h9000_0000 | ($urandom & 32'h0000_FFFF);
          default: a = $urandom;
        endcase
      endcase
      caddr = a;
      exp = 3'(1 << ref_sel(a));
      @(negedge clk);
      vectors++; if (ocv !== exp) begin errors++; $display("FAIL decode_valid addr %h got %b want %b", a, ocv, exp); end
      vectors++; if (oaddr !== {N{a}}) begin errors++; $display("FAIL decode_bcast got %h want %h", oaddr, {N{a}}); end
      vectors++; if (cr !== 1'b0) begin errors++; $display("FAIL decode_ready got %b want 0", cr); end
      @(posedge clk); #1;
    end
    idle();
  endtask

  task automatic test_ordering;
    do_reset();
    cv = 1'b1; cread = 1'b1; caddr = 32'h8000_0010; ocr = 3'b111;
    @(negedge clk);
    vectors++; if (ocv !== 3'b001 || cr !== 1'b1) begin errors++; $display("FAIL order_first got v=%b r=%b want 001/1", ocv, cr); end
    @(posedge clk); #1;
    caddr = 32'h1000_0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++; if (ocv !== 3'b000 || cr !== 1'b0) begin errors++; $display("FAIL order_stall got v=%b r=%b want 000/0", ocv, cr); end
      @(posedge clk); #1;
    end
    orv[0] = 1'b1; ordata[31:0] = 32'h1234; rr = 1'b1;
    @(negedge clk);
    vectors++; if (rv !== 1'b1 || rdata !== 32'h1234) begin errors++; $display("FAIL order_rsp got v=%b d=%h want 1/1234", rv, rdata); end
    vectors++; if (orr !== 3'b001) begin errors++; $display("FAIL order_rsp_ready got %b want 001", orr); end
    vectors++; if (cr !== 1'b0) begin errors++; $display("FAIL order_same_cycle got %b want 0", cr); end
    @(posedge clk); #1;
    orv = 3'b000; rr = 1'b0;
    @(negedge clk);
    vectors++; if (ocv !== 3'b100 || cr !== 1'b1) begin errors++; $display("FAIL order_release got v=%b r=%b want 100/1", ocv, cr); end
    @(posedge clk); #1;
    cv = 1'b0; orv[2] = 1'b1; ordata[95:64] = 32'h5678; rr = 1'b1;
    @(negedge clk);
    vectors++; if (rv !== 1'b1 || rdata !== 32'h5678 || orr !== 3'b100) begin
      errors++; $display("FAIL order_rsp2 got v=%b d=%h rdy=%b want 1/5678/100", rv, rdata, orr); end
    @(posedge clk); #1;
    orv = 3'b000; rr = 1'b0;
    @(negedge clk);
    vectors++; if (lsu_active !== 1'b0) begin errors++; $display("FAIL order_drained got %b want 0", lsu_active); end
    @(posedge clk); #1;
  endtask

  task automatic test_full;
    do_reset();
    cv = 1'b1; caddr = 32'h9000_0004; ocr = 3'b111;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++; if (ocv !== 3'b010 || cr !== 1'b1) begin errors++; $display("FAIL full_fill%0d got v=%b r=%b want 010/1", i, ocv, cr); end
      @(posedge clk); #1;
    end
    @(negedge clk);
    vectors++; if (ocv !== 3'b000 || cr !== 1'b0) begin errors++; $display("FAIL full_block got v=%b r=%b want 000/0", ocv, cr); end
    @(posedge clk); #1;
    orv[1] = 1'b1; ordata[63:32] = 32'hD0; rr = 1'b1;
    @(negedge clk);
    vectors++; if (rv !== 1'b1 || cr !== 1'b0) begin errors++; $display("FAIL full_pop_cycle got v=%b r=%b want 1/0", rv, cr); end
    @(posedge clk); #1;
    orv = 3'b000; rr = 1'b0;
    @(negedge clk);
    vectors++; if (ocv !== 3'b010 || cr !== 1'b1) begin errors++; $display("FAIL full_release got v=%b r=%b want 010/1", ocv, cr); end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++; if (cr !== 1'b0) begin errors++; $display("FAIL full_again got %b want 0", cr); end
    @(posedge clk); #1;
    cv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      orv[1] = 1'b1; ordata[63:32] = 32'hE0 + 32'(i); rr = 1'b1;
      @(negedge clk);
      vectors++; if (rv !== 1'b1 || rdata !== 32'hE0 + 32'(i) || lsu_active !== 1'b1) begin
        errors++; $display("FAIL full_drain%0d got v=%b d=%h a=%b", i, rv, rdata, lsu_active); end
      @(posedge clk); #1;
    end
    orv = 3'b000; rr = 1'b0;
    @(negedge clk);
    vectors++; if (lsu_active !== 1'b0 || rv !== 1'b0) begin errors++; $display("FAIL full_empty got a=%b v=%b want 0/0", lsu_active, rv); end
    @(posedge clk); #1;
  endtask

  task automatic test_push_pop;
    do_reset();
    cv = 1'b1; caddr = 32'h9000_0100; ocr = 3'b111;
    repeat (2) begin
      @(negedge clk);
      vectors++; if (cr !== 1'b1) begin errors++; $display("FAIL pp_fill got %b want 1", cr); end
      @(posedge clk); #1;
    end
    orv[1] = 1'b1; ordata[63:32] = 32'hA; rr = 1'b1;
    @(negedge clk);
    vectors++; if (cr !== 1'b1 || rv !== 1'b1 || rdata !== 32'hA) begin
      errors++; $display("FAIL pp_both got r=%b v=%b d=%h want 1/1/a", cr, rv, rdata); end
    @(posedge clk); #1;
    cv = 1'b0; ordata[63:32] = 32'hB;
    @(negedge clk);
    vectors++; if (rv !== 1'b1 || rdata !== 32'hB || lsu_active !== 1'b1) begin
      errors++; $display("FAIL pp_b got v=%b d=%h a=%b", rv, rdata, lsu_active); end
    @(posedge clk); #1;
    ordata[63:32] = 32'hC;
    @(negedge clk);
    vectors++; if (rv !== 1'b1 || rdata !== 32'hC || lsu_active !== 1'b1) begin
      errors++; $display("FAIL pp_c got v=%b d=%h a=%b", rv, rdata, lsu_active); end
    @(posedge clk); #1;
    orv = 3'b000; rr = 1'b0;
    @(negedge clk);
    vectors++; if (lsu_active !== 1'b0) begin errors++; $display("FAIL pp_count got %b want 0", lsu_active); end
    @(posedge clk); #1;
  endtask

  task automatic test_excl;
    do_reset();
    ocr = 3'b111; cv = 1'b1; cread = 1'b1; cexcl = 1'b1; caddr = 32'h8000_0000;
    @(negedge clk);
    vectors++; if (cr !== 1'b1) begin errors++; $display("FAIL excl_lr got %b want 1", cr); end
    @(posedge clk); #1;
    cv = 1'b0; orv[0] = 1'b1; rr = 1'b1; ook[0] = 1'b1;
    @(posedge clk); #1;
    orv = 3'b000; rr = 1'b0;
`ifdef E203_LSU_EXCL_MON_EN
    cv = 1'b1; cread = 1'b0; cwmask = 4'hF;
    @(negedge clk);
    vectors++; if (owmask !== 12'hFFF || cr !== 1'b1) begin errors++; $display("FAIL excl_sc_ok_mask got %h want fff", owmask); end
    @(posedge clk); #1;
    cv = 1'b0; orv[0] = 1'b1; rr = 1'b1; ook[0] = 1'b1;
    @(negedge clk);
    vectors++; if (rok !== 1'b1 || rv !== 1'b1) begin errors++; $display("FAIL excl_sc_ok got %b want 1", rok); end
    @(posedge clk); #1;
    orv = 3'b000; rr = 1'b0;
    cv = 1'b1; cread = 1'b1;
    @(posedge clk); #1;
    cv = 1'b0; orv[0] = 1'b1; rr = 1'b1;
    @(posedge clk); #1;
    orv = 3'b000; rr = 1'b0; commit_trap = 1'b1;
    @(posedge clk); #1;
    commit_trap = 1'b0; cv = 1'b1; cread = 1'b0; cwmask = 4'hF;
    @(negedge clk);
    vectors++; if (owmask !== 12'h000 || cr !== 1'b1) begin errors++; $display("FAIL excl_sc_fail_mask got %h want 000", owmask); end
    @(posedge clk); #1;
    cv = 1'b0; orv[0] = 1'b1; rr = 1'b1; ook[0] = 1'b1;
    @(negedge clk);
    vectors++; if (rok !== 1'b0 || rv !== 1'b1) begin errors++; $display("FAIL excl_sc_fail got %b want 0", rok); end
`else
    cv = 1'b1; cread = 1'b0; cwmask = 4'h5;
    @(negedge clk);
    vectors++; if (owmask !== 12'h555) begin errors++; $display("FAIL excl_pass_mask got %h want 555", owmask); end
    @(posedge clk); #1;
    cv = 1'b0; orv[0] = 1'b1; rr = 1'b1; ook[0] = 1'b1;
    @(negedge clk);
    vectors++; if (rok !== 1'b1 || rv !== 1'b1) begin errors++; $display("FAIL excl_pass_ok got %b want 1", rok); end
`endif
    @(posedge clk); #1;
    idle();
  endtask

  task automatic test_reset_midflight;
    do_reset();
    cv = 1'b1; caddr = 32'h9000_0040; ocr = 3'b111;
    repeat (3) @(posedge clk);
    #1;
    cv = 1'b0; orv[1] = 1'b1; rr = 1'b1;
    @(negedge clk);
    vectors++; if (orr !== 3'b010 || rv !== 1'b1) begin errors++; $display("FAIL mid_before got rdy=%b v=%b want 010/1", orr, rv); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (orr !== 3'b000 || rv !== 1'b0) begin errors++; $display("FAIL mid_rsp got rdy=%b v=%b want 000/0", orr, rv); end
    vectors++; if (lsu_active !== 1'b0) begin errors++; $display("FAIL mid_active got %b want 0", lsu_active); end
    excp_active = 1'b1; #1;
    vectors++; if (lsu_active !== 1'b1) begin errors++; $display("FAIL mid_excp got %b want 1", lsu_active); end
    @(negedge clk);
    rst_n = 1'b1; excp_active = 1'b0;
    @(negedge clk);
    vectors++; if (orr !== 3'b000 || rv !== 1'b0 || lsu_active !== 1'b0) begin
      errors++; $display("FAIL mid_after got rdy=%b v=%b a=%b want 000/0/0", orr, rv, lsu_active); end
    @(posedge clk); #1;
    idle();
  endtask

  task automatic test_random;
    ent_t e;
    int s, h;
    bit blk, push, pop, exp_cr, exp_rv;
    logic [2:0] exp_ocv, exp_orr;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      cv = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0: caddr = 32'h8000_0000 | ($urandom & 32'h0000_FFFF);
        1: caddr = 32'h9000_0000 | ($urandom & 32'h0000_FFFF);
        default: caddr = {4'h1, 28'($urandom)};
      endcase
      cread = 1'($urandom_range(0, 1)); cwdata = $urandom; cwmask = 4'($urandom);
      csize = 2'($urandom); ocr = 3'($urandom); rr = 1'($urandom_range(0, 1));
      excp_active = ($urandom_range(0, 7) == 0);
      orv = 3'($urandom); oerr = 3'($urandom); ook = 3'($urandom);
      for (int k = 0; k < N; k++) ordata[k*DW +: DW] = $urandom;
      if (q.size() > 0) begin
        ordata[q[0].tgt*DW +: DW] = q[0].data;
        oerr[q[0].tgt] = q[0].err;
      end
      @(negedge clk);
      s = ref_sel(caddr);
      blk = (q.size() == D) || (q.size() > 0 && q[q.size()-1].tgt != s);
      exp_cr = !blk && ocr[s];
      exp_ocv = (cv && !blk) ? 3'(1 << s) : 3'b000;
      exp_rv = (q.size() > 0) ? orv[q[0].tgt] : 1'b0;
      exp_orr = (q.size() > 0 && rr) ? 3'(1 << q[0].tgt) : 3'b000;
      vectors++; if (cr !== exp_cr) begin errors++; $display("FAIL rnd_cmd_ready n=%0d got %b want %b", n, cr, exp_cr); end
      vectors++; if (ocv !== exp_ocv) begin errors++; $display("FAIL rnd_cmd_valid n=%0d got %b want %b", n, ocv, exp_ocv); end
      vectors++; if (owmask !== {N{cwmask}} || owdata !== {N{cwdata}}) begin errors++; $display("FAIL rnd_bcast n=%0d got %h want %h", n, owmask, {N{cwmask}}); end
      vectors++; if (rv !== exp_rv) begin errors++; $display("FAIL rnd_rsp_valid n=%0d got %b want %b", n, rv, exp_rv); end
      vectors++; if (orr !== exp_orr) begin errors++; $display("FAIL rnd_rsp_ready n=%0d got %b want %b", n, orr, exp_orr); end
      vectors++; if (lsu_active !== (q.size() != 0 || cv || excp_active)) begin
        errors++; $display("FAIL rnd_active n=%0d got %b", n, lsu_active); end
      if (exp_rv) begin
        h = q[0].tgt;
        vectors++; if (rdata !== q[0].data || rerr !== q[0].err || rok !== ook[h]) begin
          errors++; $display("FAIL rnd_rsp_data n=%0d got %h/%b/%b want %h/%b/%b", n, rdata, rerr, rok, q[0].data, q[0].err, ook[h]); end
      end
      push = cv && exp_cr;
      pop = exp_rv && rr;
      @(posedge clk); #1;
      if (pop) void'(q.pop_front());
      if (push) begin
        e.tgt = s; e.data = $urandom; e.err = 1'($urandom_range(0, 1));
        q.push_back(e);
      end
    end
    idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rbase = {32'h0000_0000, 32'h9000_0000, 32'h8000_0000};
    rmask = {32'h0000_0000, 32'hFFFF_0000, 32'hFFFF_0000};
    idle();
    test_reset();
    test_decode();
    test_ordering();
    test_full();
    test_push_pop();
    test_excl();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/e203_lsu_icb_router.md
# e203_lsu_icb_router

Parametrised successor to the LSU memory-routing layer. It takes one LSU-side ICB initiator and decodes every command by address region onto N_TGT target ICB ports (ITCM, DTCM, BIU, …). A depth-configurable outstanding FIFO keeps responses in order, and an optional exclusive (LR/SC) reservation monitor sits alongside. It lives between lsu_ctrl and the memory ports, replacing fixed per-target wiring with a generic N-way router.

## Interface
- N_TGT, 3: number of target ports; index N_TGT-1 is the default target (BIU).
- AW, 32: address width.
- DW, 32: data width; wmask is DW/8.
- OUTS_DEPTH, 4: maximum outstanding commands, 1..16.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- commit_mret, commit_trap  in  1 each  clear the reservation.
- excp_active  in  1  keeps lsu_active high.
- lsu_active  out  1  clock-gating request.
- i_icb_cmd_valid/ready  in/out  1  initiator command handshake.
- i_icb_cmd_addr  in  AW; i_icb_cmd_read  in  1; i_icb_cmd_wdata  in  DW; i_icb_cmd_wmask  in  DW/8; i_icb_cmd_lock, i_icb_cmd_excl  in  1; i_icb_cmd_size  in  2.
- i_icb_rsp_valid/ready  out/in  1; i_icb_rsp_err, i_icb_rsp_excl_ok  out  1; i_icb_rsp_rdata  out  DW.
- tgt_region_base, tgt_region_mask  in  N_TGT*AW  per-target region; target k hits when (addr & mask_k) == (base_k & mask_k).
- o_icb_cmd_valid  out  N_TGT; o_icb_cmd_ready  in  N_TGT; o_icb_cmd_addr  out  N_TGT*AW; o_icb_cmd_read/lock/excl  out  N_TGT; o_icb_cmd_wdata  out  N_TGT*DW; o_icb_cmd_wmask  out  N_TGT*DW/8; o_icb_cmd_size  out  N_TGT*2.
- o_icb_rsp_valid  in  N_TGT; o_icb_rsp_ready  out  N_TGT; o_icb_rsp_err, o_icb_rsp_excl_ok  in  N_TGT; o_icb_rsp_rdata  in  N_TGT*DW.

## Operation
- **Target select.** sel is the lowest index k < N_TGT-1 that hits. With no hit, sel = N_TGT-1. The region of index N_TGT-1 is ignored.
- **Command broadcast.** Command fields go to every target. Only o_icb_cmd_valid[sel] is asserted.
- **Ordering rule.** A command is blocked (i_icb_cmd_ready=0, no target valid) when either:
  - the FIFO is full, or
  - the FIFO is non-empty and sel differs from the target id of the most recent entry.
- **Otherwise** i_icb_cmd_ready = o_icb_cmd_ready[sel] and o_icb_cmd_valid[sel] = i_icb_cmd_valid.
- **Push.** An accepted command pushes {tgt_id, excl_fail} into the outstanding FIFO.
- **Response path.** The head entry's tgt_id selects the response:
  - i_icb_rsp_* = o_icb_rsp_*[head];
  - o_icb_rsp_ready[head] = i_icb_rsp_ready;
  - all other o_icb_rsp_ready = 0;
  - with the FIFO empty, all o_icb_rsp_ready = 0 and i_icb_rsp_valid = 0.
- **Pop.** Occurs on the i_icb_rsp handshake. Push and pop in the same cycle leave the count unchanged. The pointers wrap modulo OUTS_DEPTH.
- **Activity.** lsu_active = (count != 0) | i_icb_cmd_valid | excp_active.

## Timing
- Command and response paths are combinational: zero-cycle latency in both directions.
- FIFO count and pointers update at the posedge after the handshake. The full and last-target-id blocking conditions are evaluated from registered state only.
- The full boundary releases one cycle after a pop.
- **Reset values:**
  - count = 0 and pointers = 0;
  - reservation invalid;
  - i_icb_rsp_valid = 0 and all o_icb_rsp_ready = 0;
  - command outputs follow the inputs combinationally.
- **Reset asserted mid-transaction:**
  - the FIFO and reservation clear immediately;
  - in-flight target responses are never acknowledged;
  - targets are reset by the same rst_n.

## Configuration
- **E203_LSU_EXCL_MON_EN defined.** The router maintains a reservation (valid bit plus AW-bit address register).
  - An accepted excl read sets valid and captures the address.
  - An accepted excl write clears valid.
  - commit_mret or commit_trap clears valid. If they coincide with an excl-read accept, the set wins.
  - An excl write with valid=1 and a matching address is forwarded normally and pushes excl_fail=0.
  - Otherwise the excl write is forwarded with wmask forced to 0 and pushes excl_fail=1. Its response then reports i_icb_rsp_excl_ok=0 regardless of the target.
  - When excl_fail=0, excl_ok passes through from the target.
- **E203_LSU_EXCL_MON_EN undefined.** There is no monitor. wmask and excl_ok pass through unchanged, and the FIFO holds tgt_id only.

## Test plan
- **Region decode.** Set N_TGT=3, region0 base 0x8000_0000 mask 0xFFFF_0000, region1 base 0x9000_0000 mask 0xFFFF_0000.
  - Read 0x8000_0010 -> o_icb_cmd_valid=3'b001.
  - Read 0x9000_0004 -> 3'b010.
  - Read 0x1000_0000 -> 3'b100.
- **Ordering stall.** A read to target 0 is outstanding and unanswered; a read to target 2 is presented -> i_icb_cmd_ready=0 until the target-0 response handshake, then it is accepted the next cycle.
- **Full boundary.** Set OUTS_DEPTH=4 and issue 4 reads to target 1 with rsp_ready low -> the 5th is blocked. Pop one -> the 5th is accepted the following cycle and count stays at 4.
- **Simultaneous push/pop.** With count=2, a command accept and a response handshake occur in the same cycle -> count=2 and the rdata order is preserved (0xA, 0xB, 0xC).
- **Exclusive monitor** (macro on).
  - LR at 0x8000_0000, then SC at 0x8000_0000 -> wmask unchanged and excl_ok=1.
  - LR, commit_trap, SC -> wmask=0 and excl_ok=0.
- **Reset mid-flight.** With 3 outstanding reads, pulse rst_n low asynchronously -> count=0, lsu_active = excp_active, all o_icb_rsp_ready=0.
